// File: rtl/block_stream_writer_if.sv
// Command and character-stream channels of block_stream_writer.
// The DUT takes the slave modport; a command source / character sink takes master.
interface block_stream_writer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_char;
  logic [3:0] cmd_len;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;

  modport slave (
    input  cmd_valid, cmd_op, cmd_char, cmd_len, out_ready,
    output cmd_ready, out_char, out_valid
  );

  modport master (
    output cmd_valid, cmd_op, cmd_char, cmd_len, out_ready,
    input  cmd_ready, out_char, out_valid
  );
endinterface

// File: rtl/block_stream_writer.sv
// Turns BEGIN/END/WORD commands into a well-nested ASCII token stream, one char per beat.
// Optional macro BLOCK_STREAM_WRITER_CLOSE_ALL_EN enables op 11 (emit "end " until depth 0).
module block_stream_writer #(
  parameter int DEPTH_W = 8,
  parameter bit UPPER   = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  block_stream_writer_if.slave bus,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced
);

  typedef enum logic [1:0] {IDLE, EMIT, SEP} state_t;
  typedef enum logic [1:0] {TK_BEGIN, TK_END, TK_WORD} tok_t;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  state_t             state_q, state_d;
  tok_t               tok_q, tok_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [3:0]         idx_q, idx_d;
  logic [3:0]         len_q, len_d;
  logic [7:0]         char_q, char_d;
  logic               err_q, err_d;
`ifdef BLOCK_STREAM_WRITER_CLOSE_ALL_EN
  logic               clall_q, clall_d;
`endif

  function automatic logic [7:0] kw_case(input logic [7:0] c);
    return UPPER ? (c - 8'h20) : c;
  endfunction

  function automatic logic [7:0] tok_char(input tok_t t, input logic [3:0] i,
                                          input logic [7:0] w);
    logic [7:0] c;
    c = w;
    case (t)
      TK_BEGIN: begin
        case (i)
          4'd0:    c = kw_case(8'h62);
          4'd1:    c = kw_case(8'h65);
          4'd2:    c = kw_case(8'h67);
          4'd3:    c = kw_case(8'h69);
          default: c = kw_case(8'h6e);
        endcase
      end
      TK_END: begin
        case (i)
          4'd0:    c = kw_case(8'h65);
          4'd1:    c = kw_case(8'h6e);
          default: c = kw_case(8'h64);
        endcase
      end
      default: c = w;
    endcase
    return c;
  endfunction

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5a)) || ((c >= 8'h61) && (c <= 8'h7a));
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tok_q   <= TK_BEGIN;
      depth_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      char_q  <= '0;
      err_q   <= 1'b0;
`ifdef BLOCK_STREAM_WRITER_CLOSE_ALL_EN
      clall_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tok_q   <= tok_d;
      depth_q <= depth_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      char_q  <= char_d;
      err_q   <= err_d;
`ifdef BLOCK_STREAM_WRITER_CLOSE_ALL_EN
      clall_q <= clall_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tok_d   = tok_q;
    depth_d = depth_q;
    idx_d   = idx_q;
    len_d   = len_q;
    char_d  = char_q;
    err_d   = 1'b0;
`ifdef BLOCK_STREAM_WRITER_CLOSE_ALL_EN
    clall_d = clall_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          // Depth moves on the accept edge so the counter always reflects committed tokens.
          case (bus.cmd_op)
            2'b00: begin
              if (depth_q != DEPTH_MAX) begin
                depth_d = depth_q + DEPTH_W'(1);
                tok_d   = TK_BEGIN;
                len_d   = 4'd5;
                idx_d   = 4'd0;
                state_d = EMIT;
              end else begin
                err_d = 1'b1;
              end
            end
            2'b01: begin
              if (depth_q != '0) begin
                depth_d = depth_q - DEPTH_W'(1);
                tok_d   = TK_END;
                len_d   = 4'd3;
                idx_d   = 4'd0;
                state_d = EMIT;
              end else begin
                err_d = 1'b1;
              end
            end
            2'b10: begin
              if ((bus.cmd_len != 4'd0) && is_letter(bus.cmd_char)) begin
                tok_d   = TK_WORD;
                char_d  = bus.cmd_char;
                len_d   = bus.cmd_len;
                idx_d   = 4'd0;
                state_d = EMIT;
              end else begin
                err_d = 1'b1;
              end
            end
            default: begin
`ifdef BLOCK_STREAM_WRITER_CLOSE_ALL_EN
              if (depth_q != '0) begin
                clall_d = 1'b1;
                tok_d   = TK_END;
                len_d   = 4'd3;
                idx_d   = 4'd0;
                state_d = EMIT;
              end
`else
              err_d = 1'b1;
`endif
            end
          endcase
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (idx_q == len_q - 4'd1) state_d = SEP;
          else                       idx_d   = idx_q + 4'd1;
        end
      end
      default: begin
        if (bus.out_ready) begin
          state_d = IDLE;
`ifdef BLOCK_STREAM_WRITER_CLOSE_ALL_EN
          // Close-all unwinds one level per emitted "end ", counted on its separator beat.
          if (clall_q) begin
            depth_d = depth_q - DEPTH_W'(1);
            if (depth_q == DEPTH_W'(1)) begin
              clall_d = 1'b0;
            end else begin
              idx_d   = 4'd0;
              state_d = EMIT;
            end
          end
`endif
        end
      end
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == IDLE);
    bus.out_valid = (state_q != IDLE);
    case (state_q)
      EMIT:    bus.out_char = tok_char(tok_q, idx_q, char_q);
      SEP:     bus.out_char = 8'h20;
      default: bus.out_char = 8'h00;
    endcase
  end

  assign err      = err_q;
  assign depth    = depth_q;
  assign balanced = (depth_q == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_block_stream_writer.sv
// Directed bench for block_stream_writer: DUT a uses defaults, DUT b uses DEPTH_W=2, UPPER=1.
module tb_block_stream_writer;
  logic clk;
  logic reset;

  block_stream_writer_if ifa ();
  block_stream_writer_if ifb ();

  logic       cv   [2];
  logic [1:0] cop  [2];
  logic [7:0] cch  [2];
  logic [3:0] clen [2];
  logic       ordy [2];
  logic       crdy [2];
  logic       ovld [2];
  logic [7:0] och  [2];
  logic       errw [2];
  logic [7:0] dep  [2];
  logic       bal  [2];

  logic       erra, errb, bala, balb;
  logic [7:0] depa;
  logic [1:0] depb;

  assign ifa.cmd_valid = cv[0];   assign ifb.cmd_valid = cv[1];
  assign ifa.cmd_op    = cop[0];  assign ifb.cmd_op    = cop[1];
  assign ifa.cmd_char  = cch[0];  assign ifb.cmd_char  = cch[1];
  assign ifa.cmd_len   = clen[0]; assign ifb.cmd_len   = clen[1];
  assign ifa.out_ready = ordy[0]; assign ifb.out_ready = ordy[1];
  assign crdy[0] = ifa.cmd_ready; assign crdy[1] = ifb.cmd_ready;
  assign ovld[0] = ifa.out_valid; assign ovld[1] = ifb.out_valid;
  assign och[0]  = ifa.out_char;  assign och[1]  = ifb.out_char;
  assign errw[0] = erra;          assign errw[1] = errb;
  assign dep[0]  = depa;          assign dep[1]  = {6'd0, depb};
  assign bal[0]  = bala;          assign bal[1]  = balb;

  block_stream_writer u_dut_a (
    .clk(clk), .reset(reset), .bus(ifa), .err(erra), .depth(depa), .balanced(bala)
  );

  block_stream_writer #(.DEPTH_W(2), .UPPER(1'b1)) u_dut_b (
    .clk(clk), .reset(reset), .bus(ifb), .err(errb), .depth(depb), .balanced(balb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int beats [2] = '{0, 0};
  int mdepth [2] = '{0, 0};
  int maxd [2] = '{255, 3};
  bit upr [2] = '{1'b0, 1'b1};
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input logic [7:0] c);
    if (d == 0) q0.push_back(c);
    else        q1.push_back(c);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push_kw(input int d, input string s);
    for (int i = 0; i < s.len(); i++) push(d, upr[d] ? (s[i] - 8'h20) : s[i]);
    push(d, 8'h20);
  endtask

  // Scoreboard: a beat is sampled on the falling edge before the rising edge that takes it.
  always @(negedge clk) begin
    if (!reset && ovld[0] && ordy[0]) begin
      beats[0]++;
      if (q0.size() == 0) begin
        ncmp++; nerr++;
        $error("FAIL beat_a_unexpected observed=%0h expected=none", och[0]);
      end else chk("char_a", och[0], q0.pop_front());
    end
    if (!reset && ovld[1] && ordy[1]) begin
      beats[1]++;
      if (q1.size() == 0) begin
        ncmp++; nerr++;
        $error("FAIL beat_b_unexpected observed=%0h expected=none", och[1]);
      end else chk("char_b", och[1], q1.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [1:0] op, input logic [7:0] ch,
                      input logic [3:0] len);
    bit rej;
    int edep;
    int t;
    rej = 1'b0;
    t = 0;
    while (!crdy[d] && t < 200) begin tick(); t++; end
    chk("cmd_ready_wait", 32'(t < 200), 1);
    case (op)
      2'b00: if (mdepth[d] < maxd[d]) begin push_kw(d, "begin"); mdepth[d]++; end
             else rej = 1'b1;
      2'b01: if (mdepth[d] > 0) begin push_kw(d, "end"); mdepth[d]--; end
             else rej = 1'b1;
      2'b10: if (len != 0 && ((ch >= 8'h41 && ch <= 8'h5a) || (ch >= 8'h61 && ch <= 8'h7a))) begin
               for (int i = 0; i < int'(len); i++) push(d, ch);
               push(d, 8'h20);
             end else rej = 1'b1;
      default: begin
`ifdef BLOCK_STREAM_WRITER_CLOSE_ALL_EN
        for (int i = 0; i < mdepth[d]; i++) push_kw(d, "end");
`else
        rej = 1'b1;
`endif
      end
    endcase
    edep = mdepth[d];
`ifdef BLOCK_STREAM_WRITER_CLOSE_ALL_EN
    if (op == 2'b11) mdepth[d] = 0;
`endif
    cv[d] = 1'b1; cop[d] = op; cch[d] = ch; clen[d] = len;
    @(posedge clk);
    #1;
    cv[d] = 1'b0;
    chk("err_after_accept", errw[d], rej);
    chk("depth_after_accept", dep[d], edep);
    if (rej) begin
      chk("no_out_on_reject", ovld[d], 0);
      tick();
      chk("err_one_cycle", errw[d], 0);
      chk("ready_after_reject", crdy[d], 1);
      chk("no_out_after_reject", ovld[d], 0);
    end
  endtask

  task automatic wait_idle(input int d);
    int t;
    t = 0;
    while (!(crdy[d] && !ovld[d]) && t < 500) begin tick(); t++; end
    chk("idle_wait", 32'(t < 500), 1);
    tick();
    chk("scoreboard_drained", qsize(d), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    for (int d = 0; d < 2; d++) begin
      cv[d] = 1'b0; cop[d] = 2'b00; cch[d] = 8'h00; clen[d] = 4'd0; ordy[d] = 1'b1;
    end
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    chk("rst_out_valid", ovld[0], 0);
    chk("rst_out_char", och[0], 8'h00);
    chk("rst_err", errw[0], 0);
    chk("rst_cmd_ready", crdy[0], 1);
    chk("rst_balanced", bal[0], 1);
    chk("rst_depth", dep[0], 0);

    // begin xxx end
    b0 = beats[0];
    send(0, 2'b00, 8'h00, 4'd0);
    send(0, 2'b10, 8'h78, 4'd3);
    send(0, 2'b01, 8'h00, 4'd0);
    wait_idle(0);
    chk("t1_beats", beats[0] - b0, 14);
    chk("t1_balanced", bal[0], 1);

    // rejected commands
    send(0, 2'b01, 8'h00, 4'd0);
    chk("end_d0_balanced", bal[0], 1);
    send(0, 2'b10, 8'h61, 4'd0);
    send(0, 2'b10, 8'h35, 4'd4);
`ifdef BLOCK_STREAM_WRITER_CLOSE_ALL_EN
    send(0, 2'b11, 8'h00, 4'd0);
    chk("closeall_d0_noout", ovld[0], 0);
`else
    send(0, 2'b11, 8'h00, 4'd0);
`endif

    // backpressure on the first character
    ordy[0] = 1'b0;
    send(0, 2'b00, 8'h00, 4'd0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_char", och[0], 8'h62);
      chk("stall_valid", ovld[0], 1);
      tick();
    end
    ordy[0] = 1'b1;
    wait_idle(0);
    send(0, 2'b01, 8'h00, 4'd0);
    wait_idle(0);

    // reset mid-token after two beats
    send(0, 2'b00, 8'h00, 4'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_valid", ovld[0], 0);
    chk("midrst_depth", dep[0], 0);
    chk("midrst_balanced", bal[0], 1);
    chk("midrst_beats_taken", 32'(q0.size()), 4);
    q0.delete();
    q1.delete();
    mdepth[0] = 0;
    mdepth[1] = 0;
    tick();
    reset = 1'b0;
    tick();
    send(0, 2'b00, 8'h00, 4'd0);
    chk("restart_char", och[0], 8'h62);
    wait_idle(0);
    send(0, 2'b01, 8'h00, 4'd0);
    wait_idle(0);

    // DEPTH_W=2, UPPER=1
    for (int i = 0; i < 4; i++) send(1, 2'b00, 8'h00, 4'd0);
    wait_idle(1);
    chk("b_depth_max", dep[1], 3);
    send(1, 2'b01, 8'h00, 4'd0);
    send(1, 2'b10, 8'h71, 4'd1);
    wait_idle(1);
    chk("b_depth_after", dep[1], 2);

`ifdef BLOCK_STREAM_WRITER_CLOSE_ALL_EN
    for (int i = 0; i < 3; i++) send(0, 2'b00, 8'h00, 4'd0);
    b0 = beats[0];
    send(0, 2'b11, 8'h00, 4'd0);
    wait_idle(0);
    chk("closeall_beats", beats[0] - b0, 12);
    chk("closeall_depth", dep[0], 0);
    chk("closeall_balanced", bal[0], 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
